ram_burst_ctrl: RTL and testbench
=================================

# ram_burst_ctrl

Burst access controller sitting directly upstream of the 256×32 banked RAM (four 64-word banks selected by address bits [7:6]). Accepts single- or multi-word read/write requests from a host over valid/ready handshakes and drives the RAM's address, data-in, write and enable pins. Read data is captured from the RAM output and returned over a response stream. It serialises all RAM traffic so the bank decoder only ever sees one access per cycle.

## Interface
- ADDR_W, 8, RAM word address width; 256 words
- DATA_W, 32, RAM word width
- LEN_W, 4, burst length field width; bursts are 1–16 words
- Clk  in  1  single clock; all state updates on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  host request present
- req_ready  out  1  controller can accept a request; only in IDLE
- req_wr  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_W  burst start address
- req_len  in  LEN_W  burst length minus one
- wdata_valid  in  1  write word present
- wdata_ready  out  1  controller accepts write word this cycle
- wdata  in  DATA_W  write word
- rdata_valid  out  1  read word present
- rdata_ready  in  1  host accepts read word
- rdata  out  DATA_W  read word
- done  out  1  one-cycle pulse at burst completion
- busy  out  1  high in any state but IDLE
- ram_addr  out  ADDR_W  to RAM Address
- ram_din  out  DATA_W  to RAM Din
- ram_wr  out  1  to RAM WR
- ram_en  out  1  to RAM en
- ram_dout  in  DATA_W  from RAM Dout

## Operation
- States: IDLE, WR_BURST, RD_ADDR, RD_DATA, FINISH.
- IDLE: req_ready=1. On req_valid: latch req_addr into cur_addr and req_len into remaining. Go to WR_BURST if req_wr=1, else RD_ADDR.
- WR_BURST: wdata_ready=1. On wdata_valid, in the same cycle: ram_en=1, ram_wr=1, ram_addr=cur_addr, ram_din=wdata. The RAM writes on that rising edge.
  - If remaining==0, go to FINISH; else cur_addr+1 and remaining−1.
  - With wdata_valid=0: ram_en=0 and state holds. Stalls are unbounded.
- RD_ADDR: ram_en=1, ram_wr=0, ram_addr=cur_addr for one cycle, then RD_DATA.
- RD_DATA: on entry, rdata is registered from ram_dout and rdata_valid=1. rdata and rdata_valid hold until rdata_ready.
  - On the handshake: if remaining==0 go to FINISH; else increment/decrement as in WR_BURST and go to RD_ADDR.
- FINISH: done=1 for one cycle, then IDLE.
- Address arithmetic is modulo 256: 255+1 wraps to 0, so a burst may cross any bank boundary.
- ram_en=0 and ram_wr=0 in IDLE, RD_DATA and FINISH. ram_wr is never 1 unless ram_en is 1.
- req_valid outside IDLE is ignored; it is not queued.

## Timing
- Reset (Rst_n low, asynchronous): state=IDLE, cur_addr=0, remaining=0. Outputs: req_ready=0, wdata_ready=0, rdata_valid=0, rdata=0, done=0, busy=0, ram_en=0, ram_wr=0, ram_addr=0, ram_din=0.
- req_ready rises on the first rising Clk edge after Rst_n deasserts.
- Write throughput: 1 word/cycle. Read throughput: 1 word per 2 cycles at best.
- Read latency: req handshake → first rdata_valid = 2 cycles.
- Last write or read handshake → done 1 cycle later; req_ready 1 cycle after done.
- Reset mid-burst aborts the burst immediately: no done pulse; the RAM keeps any words already written.

## Structure
- Shared package ram_ctrl_pkg: state enum, ADDR_W/DATA_W/LEN_W defaults, RAM_WORDS=256.
- One sub-module, ram_burst_counter: holds cur_addr/remaining with load, step and last flag.
- The FSM and datapath stay in ram_burst_ctrl. Bench RAM model: behavioural 256×32 memory with synchronous write and 1-cycle read.

## Test plan
- Single write addr 0x05, data 0xDEADBEEF, then single read 0x05 → rdata=0xDEADBEEF 2 cycles after the read request handshake; one done pulse per burst.
- Write burst addr 0x3E, len=3 (4 words), data 0x11..0x44 → RAM[0x3E..0x41] written, crossing bank 0→1; read-back matches.
- Write burst addr 0xFE, len=2 → words land at 0xFE, 0xFF, 0x00 (wrap); a read burst from 0xFE returns the same 3 words.
- Read burst len=15 with rdata_ready held low 5 cycles on word 3 → rdata stable throughout the stall; ram_en never asserts during the stall; 16 words in order.
- wdata_valid gaps during a 4-word write → ram_en high only on handshake cycles; req_valid pulsed while busy is ignored.
- Rst_n low mid write burst after 2 words → all outputs at reset values asynchronously; req_ready=1 one edge after release; no done pulse.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared widths, RAM size and FSM state type for the burst controller
package ram_ctrl_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int LEN_W = 4;
  localparam int RAM_WORDS = 256;
  typedef enum logic [2:0] {IDLE, WR_BURST, RD_ADDR, RD_DATA, FINISH} state_t;
endpackage

// File: rtl/ram_burst_ctrl_if.sv
// ram_burst_ctrl_if: host-side request, write-data, read-data and status signals
interface ram_burst_ctrl_if;
  import ram_ctrl_pkg::*;
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rdata_valid;
  logic              rdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic              busy;
  modport master (
    output req_valid, req_wr, req_addr, req_len, wdata_valid, wdata, rdata_ready,
    input  req_ready, wdata_ready, rdata_valid, rdata, done, busy
  );
  modport slave (
    input  req_valid, req_wr, req_addr, req_len, wdata_valid, wdata, rdata_ready,
    output req_ready, wdata_ready, rdata_valid, rdata, done, busy
  );
endinterface

// File: rtl/ram_burst_counter.sv
// ram_burst_counter: current burst address and words remaining, with last-word flag
module ram_burst_counter
  import ram_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [LEN_W-1:0] remaining;
  // address wraps modulo RAM size, so bursts may cross any bank boundary
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      remaining <= '0;
    end else if (load) begin
      addr <= load_addr;
      remaining <= load_len;
    end else if (step) begin
      addr <= addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  assign last = remaining == '0;
endmodule

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: serialises host read/write bursts onto the single-port banked RAM
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  ram_burst_ctrl_if.slave   host,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wr,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_dout
);
  state_t state, state_nx;
  logic up, fresh, load, step, last, wr_hs, rd_hs;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] cur_addr;
  ram_burst_counter u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .step(step),
    .load_addr(host.req_addr),
    .load_len(host.req_len),
    .addr(cur_addr),
    .last(last)
  );
  // up keeps req_ready low until the first edge after reset release;
  // fresh marks the first RD_DATA cycle, when the RAM output is passed straight through
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      up <= 1'b0;
      fresh <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      up <= 1'b1;
      fresh <= state == RD_ADDR;
      if (fresh) rdata_q <= ram_dout;
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (load) state_nx = host.req_wr ? WR_BURST : RD_ADDR;
      WR_BURST: if (wr_hs && last) state_nx = FINISH;
      RD_ADDR:  state_nx = RD_DATA;
      RD_DATA:  if (rd_hs) state_nx = last ? FINISH : RD_ADDR;
      FINISH:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  assign host.req_ready = up && state == IDLE;
  assign host.wdata_ready = state == WR_BURST;
  assign host.rdata_valid = state == RD_DATA;
  assign host.rdata = fresh ? ram_dout : rdata_q;
  assign host.done = state == FINISH;
  assign host.busy = state != IDLE;
  assign load = host.req_ready && host.req_valid;
  assign wr_hs = host.wdata_ready && host.wdata_valid;
  assign rd_hs = host.rdata_valid && host.rdata_ready;
  assign step = (wr_hs || rd_hs) && !last;
  assign ram_en = wr_hs || state == RD_ADDR;
  assign ram_wr = wr_hs;
  assign ram_addr = cur_addr;
  assign ram_din = wr_hs ? host.wdata : '0;
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: table, directed and random bursts against a shadow-memory model
module tb_ram_burst_ctrl;
  import ram_ctrl_pkg::*;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [3:0]  len;
    logic [31:0] d0;
    logic [31:0] ds;
    int          exp_done;
  } vec_t;

  logic clk, rst_n;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;
  logic ram_wr, ram_en;
  logic [DATA_W-1:0] mem [RAM_WORDS];
  logic [DATA_W-1:0] ref_mem [RAM_WORDS];
  int checks, errors, cyc, done_cnt, exp_dones;
  vec_t tbl [6];

  ram_burst_ctrl_if bus ();

  ram_burst_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .host(bus),
    .ram_addr(ram_addr),
    .ram_din(ram_din),
    .ram_wr(ram_wr),
    .ram_en(ram_en),
    .ram_dout(ram_dout)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < RAM_WORDS; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
  end

  always @(posedge clk)
    if (ram_en) begin
      if (ram_wr) mem[ram_addr] <= ram_din;
      else ram_dout <= mem[ram_addr];
    end

  always @(negedge clk)
    if (rst_n) begin
      if (bus.done) done_cnt++;
      checks++;
      if (ram_wr && !(ram_en && bus.wdata_valid && bus.wdata_ready && ram_din == bus.wdata)) begin
        errors++;
        $display("FAIL mon_write ram_wr=%b ram_en=%b wdata_valid=%b ram_din=%h wdata=%h",
                 ram_wr, ram_en, bus.wdata_valid, ram_din, bus.wdata);
      end
      checks++;
      if (ram_en && !ram_wr && bus.rdata_valid) begin
        errors++;
        $display("FAIL mon_read_en ram_en=1 while rdata_valid=1");
      end
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_wdata_ready"}, bus.wdata_ready, 0);
    chk({tag, "_rdata_valid"}, bus.rdata_valid, 0);
    chk({tag, "_rdata"}, bus.rdata, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_ram_en"}, ram_en, 0);
    chk({tag, "_ram_wr"}, ram_wr, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_din"}, ram_din, 0);
  endtask

  task automatic req(input logic wr, input logic [7:0] a, input logic [3:0] len);
    int t;
    t = 0;
    bus.req_valid = 1;
    bus.req_wr = wr;
    bus.req_addr = a;
    bus.req_len = len;
    @(negedge clk);
    while (!bus.req_ready && t < 50) begin
      tick();
      @(negedge clk);
      t++;
    end
    chk("req_accept", bus.req_ready, 1);
    tick();
    cyc = 0;
    bus.req_valid = 0;
  endtask

  task automatic wr_data(input logic [7:0] a, input int n, input logic [31:0] d0,
                         input logic [31:0] ds, input int gap, input bit poke);
    int g;
    for (int i = 0; i < n; i++) begin
      g = gap > 0 ? int'($urandom_range(gap)) : 0;
      if (gap > 0 && i == 1 && g == 0) g = 1;
      bus.wdata_valid = 0;
      bus.wdata = d0 + ds * i;
      for (int k = 0; k < g; k++) begin
        if (poke) begin
          bus.req_valid = 1;
          bus.req_wr = 0;
        end
        @(negedge clk);
        chk("wr_gap_en", ram_en, 0);
        chk("wr_gap_ready", bus.wdata_ready, 1);
        if (poke) chk("busy_req_ready", bus.req_ready, 0);
        tick();
        bus.req_valid = 0;
      end
      bus.wdata_valid = 1;
      @(negedge clk);
      chk("wr_ready", bus.wdata_ready, 1);
      chk("wr_en", ram_en, 1);
      chk("wr_addr", ram_addr, (int'(a) + i) % RAM_WORDS);
      ref_mem[(int'(a) + i) % RAM_WORDS] = bus.wdata;
      tick();
    end
    bus.wdata_valid = 0;
  endtask

  task automatic rd_data(input logic [7:0] a, input int n, input int stall_word,
                         input int stall_len, input int rnd);
    int t, s;
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      e = ref_mem[(int'(a) + i) % RAM_WORDS];
      t = 0;
      bus.rdata_ready = 0;
      @(negedge clk);
      while (!bus.rdata_valid && t < 8) begin
        tick();
        @(negedge clk);
        t++;
      end
      if (i == 0) chk("rd_latency", cyc, 1);
      s = (i == stall_word) ? stall_len : (rnd > 0 ? int'($urandom_range(rnd)) : 0);
      for (int k = 0; k < s; k++) begin
        chk("rd_stall_valid", bus.rdata_valid, 1);
        chk("rd_stall_data", bus.rdata, e);
        chk("rd_stall_en", ram_en, 0);
        tick();
        @(negedge clk);
      end
      bus.rdata_ready = 1;
      chk("rd_valid", bus.rdata_valid, 1);
      chk("rd_data", bus.rdata, e);
      tick();
    end
    bus.rdata_ready = 0;
  endtask

  task automatic wait_done(input int exp_cyc);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.done && t < 40) begin
      tick();
      @(negedge clk);
      t++;
    end
    chk("done", bus.done, 1);
    if (exp_cyc >= 0) chk("done_cycle", cyc, exp_cyc);
    exp_dones++;
    tick();
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
    chk("req_ready_after_done", bus.req_ready, 1);
    chk("done_count", done_cnt, exp_dones);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rw;
    logic [7:0] ra;
    logic [3:0] rl;
    int g, n;
    checks = 0; errors = 0; cyc = 0; done_cnt = 0; exp_dones = 0;
    tbl[0] = '{1'b1, 8'h05, 4'd0, 32'hDEADBEEF, 32'h0, 1};
    tbl[1] = '{1'b0, 8'h05, 4'd0, 32'hDEADBEEF, 32'h0, 2};
    tbl[2] = '{1'b1, 8'h3E, 4'd3, 32'h11, 32'h11, 4};
    tbl[3] = '{1'b0, 8'h3E, 4'd3, 32'h11, 32'h11, 8};
    tbl[4] = '{1'b1, 8'hFE, 4'd2, 32'hA0, 32'h1, 3};
    tbl[5] = '{1'b0, 8'hFE, 4'd2, 32'hA0, 32'h1, 6};
    rst_n = 0;
    bus.req_valid = 0; bus.req_wr = 0; bus.req_addr = '0; bus.req_len = '0;
    bus.wdata_valid = 0; bus.wdata = '0; bus.rdata_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_chk("por");
    rst_n = 1;
    #1;
    chk("req_ready_pre_edge", bus.req_ready, 0);
    tick();
    @(negedge clk);
    chk("req_ready_post_edge", bus.req_ready, 1);
    tick();

    for (int v = 0; v < 6; v++) begin
      n = int'(tbl[v].len) + 1;
      req(tbl[v].wr, tbl[v].addr, tbl[v].len);
      if (tbl[v].wr) wr_data(tbl[v].addr, n, tbl[v].d0, tbl[v].ds, 0, 1'b0);
      else rd_data(tbl[v].addr, n, -1, 0, 0);
      wait_done(tbl[v].exp_done);
      for (int i = 0; i < n; i++)
        chk("ram_word", mem[(int'(tbl[v].addr) + i) % RAM_WORDS], tbl[v].d0 + tbl[v].ds * i);
    end

    req(1'b1, 8'h40, 4'd15);
    wr_data(8'h40, 16, 32'h1000, 32'h1, 0, 1'b0);
    wait_done(16);
    req(1'b0, 8'h40, 4'd15);
    rd_data(8'h40, 16, 3, 5, 0);
    wait_done(-1);

    req(1'b1, 8'h90, 4'd3);
    wr_data(8'h90, 4, 32'h5A5A0000, 32'h101, 3, 1'b1);
    wait_done(-1);
    @(negedge clk);
    chk("poke_ignored_busy", bus.busy, 0);
    tick();
    req(1'b0, 8'h90, 4'd3);
    rd_data(8'h90, 4, -1, 0, 0);
    wait_done(8);

    req(1'b1, 8'h80, 4'd3);
    wr_data(8'h80, 2, 32'hC0DE0000, 32'h1, 0, 1'b0);
    bus.wdata_valid = 1;
    bus.wdata = 32'hBADBAD00;
    #2 rst_n = 0;
    #1 rst_chk("abort");
    bus.wdata_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_chk("abort_hold");
    rst_n = 1;
    #1;
    chk("abort_req_ready_pre_edge", bus.req_ready, 0);
    tick();
    @(negedge clk);
    chk("abort_req_ready_post_edge", bus.req_ready, 1);
    chk("abort_no_done", done_cnt, exp_dones);
    chk("abort_word0", mem[8'h80], 32'hC0DE0000);
    chk("abort_word1", mem[8'h81], 32'hC0DE0001);
    chk("abort_word2", mem[8'h82], ref_mem[8'h82]);
    tick();

    for (int r = 0; r < 20; r++) begin
      rw = 1'($urandom_range(1));
      ra = 8'($urandom);
      rl = 4'($urandom);
      g = int'($urandom_range(2));
      n = int'(rl) + 1;
      req(rw, ra, rl);
      if (rw) begin
        wr_data(ra, n, $urandom, $urandom, g, 1'($urandom_range(1)));
        wait_done(g == 0 ? n : -1);
      end else begin
        rd_data(ra, n, -1, 0, g);
        wait_done(g == 0 ? 2 * n : -1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
